load_use_scoreboard: RTL

- Parametrised successor to the single-cycle load-use hazard check.
- Tracks the destination registers of in-flight loads in a shift-register scoreboard that is LOAD_LATENCY entries deep.
- Raises a multi-cycle stall while the instruction in F/D reads a register with a result still pending.
- Sits between decode and the D/X pipeline register. It drives the PC/F-D hold and the D/X bubble insert, and honours a memory-wait freeze and a branch flush.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/scoreboard_match.sv | 20 ++
 rtl/load_use_scoreboard.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions and the
// load-use scoreboard entry type.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int OPCODE_W   = 5;

  localparam logic [OPCODE_W-1:0] OPCODE_LOAD  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OPCODE_STORE = 5'b00111;

  // Field MSB positions: op [31:27], rd [26:22], rs [21:17], rt [16:12].
  localparam int OP_MSB = 31;
  localparam int RD_MSB = OP_MSB - OPCODE_W;
  localparam int RS_MSB = RD_MSB - REG_ADDR_W;
  localparam int RT_MSB = RS_MSB - REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } scoreboard_entry_t;

  function automatic scoreboard_entry_t make_entry(input logic valid,
                                                   input logic [REG_ADDR_W-1:0] rd);
    scoreboard_entry_t e;
    e.valid = valid;
    e.rd    = rd;
    return e;
  endfunction

endpackage

// File: rtl/scoreboard_match.sv
// Compares one in-flight load destination against the sources read in F/D.
// Stores only read rt as data, which can be forwarded late, so rt is ignored.
module scoreboard_match
  import pipeline_pkg::*;
(
  input  scoreboard_entry_t     entry,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  is_store,
  output logic                  match
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (rs == entry.rd);
  assign rt_hit = (rt == entry.rd) && !is_store;
  assign match  = entry.valid && (rs_hit || rt_hit);

endmodule

// File: rtl/load_use_scoreboard.sv
// Multi-cycle load-use hazard detector: a LOAD_LATENCY-deep shift register of
// pending load destinations. Optional statistics under HAZARD_STATS_EN.
module load_use_scoreboard #(
  parameter int                    REG_ADDR_W   = pipeline_pkg::REG_ADDR_W,
  parameter int                    OPCODE_W     = pipeline_pkg::OPCODE_W,
  parameter int                    LOAD_LATENCY = 1,
  parameter logic [OPCODE_W-1:0]   LOAD_OPCODE  = pipeline_pkg::OPCODE_LOAD,
  parameter logic [OPCODE_W-1:0]   STORE_OPCODE = pipeline_pkg::OPCODE_STORE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             decode_instruction,
  input  logic                    decode_valid,
  input  logic                    mem_wait,
  input  logic                    flush,
  output logic                    hazard_stall,
  output logic                    bubble_insert,
  output logic [LOAD_LATENCY-1:0] pending_mask
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [7:0]              max_stall_run
`endif
);

  localparam int RT_LSB = pipeline_pkg::RT_MSB - REG_ADDR_W + 1;

  logic [OPCODE_W-1:0]   op;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic                  is_store;
  logic                  is_load;
  logic                  unused_low_bits;

  assign op       = decode_instruction[pipeline_pkg::OP_MSB -: OPCODE_W];
  assign rd       = decode_instruction[pipeline_pkg::RD_MSB -: REG_ADDR_W];
  assign rs       = decode_instruction[pipeline_pkg::RS_MSB -: REG_ADDR_W];
  assign rt       = decode_instruction[pipeline_pkg::RT_MSB -: REG_ADDR_W];
  assign is_store = (op == STORE_OPCODE);
  assign is_load  = (op == LOAD_OPCODE);
  assign unused_low_bits = ^decode_instruction[RT_LSB-1:0];

  pipeline_pkg::scoreboard_entry_t entries      [LOAD_LATENCY];
  pipeline_pkg::scoreboard_entry_t entries_next [LOAD_LATENCY];
  logic [LOAD_LATENCY-1:0]         match_vec;
  logic                            hazard;

  for (genvar k = 0; k < LOAD_LATENCY; k++) begin : g_entry
    scoreboard_match u_match (
      .entry    (entries[k]),
      .rs       (rs),
      .rt       (rt),
      .is_store (is_store),
      .match    (match_vec[k])
    );
    assign pending_mask[k] = entries[k].valid;
  end

  // Gating with reset keeps the outputs low while reset is held, independent
  // of whatever sits in F/D.
  assign hazard        = !reset && decode_valid && !flush && (|match_vec);
  assign hazard_stall  = hazard;
  assign bubble_insert = !reset && (hazard || flush);

  always_comb begin
    entries_next[0] = pipeline_pkg::make_entry(1'b0, '0);
    if (decode_valid && !hazard && !flush && is_load && (rd != '0)) begin
      entries_next[0] = pipeline_pkg::make_entry(1'b1, rd);
    end
    for (int k = 1; k < LOAD_LATENCY; k++) begin
      entries_next[k] = entries[k-1];
      // A flush kills the load that was sitting in D/X as it moves on.
      if (k == 1 && flush) begin
        entries_next[k].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LOAD_LATENCY; k++) begin
        entries[k] <= pipeline_pkg::make_entry(1'b0, '0);
      end
    end else if (!mem_wait) begin
      entries <= entries_next;
    end
  end

`ifdef HAZARD_STATS_EN
  // Runs count only advancing cycles; a memory freeze neither extends nor
  // breaks the current run.
  logic [7:0] cur_run;
  logic [7:0] run_inc;

  assign run_inc = (cur_run == 8'hFF) ? cur_run : cur_run + 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles  <= '0;
      max_stall_run <= '0;
      cur_run       <= '0;
    end else if (hazard && !mem_wait) begin
      if (stall_cycles != 32'hFFFF_FFFF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      cur_run <= run_inc;
      if (run_inc > max_stall_run) begin
        max_stall_run <= run_inc;
      end
    end else if (!hazard) begin
      cur_run <= '0;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
